// File: rtl/dmux_deser_pkg.sv
// dmux_pkg: shared channel count, channel type and output FSM states for dmux_deser
package dmux_pkg;
    localparam int NCH = 4;
    typedef logic [1:0] ch_t;
    typedef enum logic {IDLE, PRESENT} state_t;
endpackage

// File: rtl/dmux_deser_lane.sv
// dmux_deser_lane: one channel's MSB-first word assembler with a single hold slot and sticky overflow
module dmux_deser_lane #(
    parameter int WW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          en,
    input  logic          din,
    input  logic          drain,
    output logic [WW-1:0] hold,
    output logic          hold_v,
    output logic          ovf
);
    localparam int CW = $clog2(WW);
    logic [WW-1:0] shreg;
    logic [WW-1:0] nxt;
    logic [CW-1:0] cnt;
    logic          done;
    assign nxt  = {shreg[WW-2:0], din};
    assign done = en && cnt == CW'(WW - 1);
    // shift bits in, move finished words to hold unless the slot is occupied and not being drained
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg  <= '0;
            cnt    <= '0;
            hold   <= '0;
            hold_v <= 1'b0;
            ovf    <= 1'b0;
        end else if (clear) begin
            shreg  <= '0;
            cnt    <= '0;
            hold   <= '0;
            hold_v <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            if (en) begin
                shreg <= nxt;
                cnt   <= done ? '0 : cnt + 1'b1;
            end
            if (done && (!hold_v || drain)) hold <= nxt;
            hold_v <= done ? 1'b1 : (drain ? 1'b0 : hold_v);
            if (done && hold_v && !drain) ovf <= 1'b1;
        end
    end
endmodule

// File: rtl/dmux_deser.sv
// dmux_deser: four-lane deserializer behind a 1:4 demux with round-robin valid/ready output (optional DMUX_DESER_PARITY_EN)
module dmux_deser
    import dmux_pkg::*;
#(
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Enable,
    input  logic [1:0]        S,
    input  logic [0:3]        O,
    input  logic              Clear,
    input  logic              Ready,
    output logic              Valid,
    output logic [WORD_W-1:0] Word_out,
    output logic [1:0]        Ch_out,
`ifdef DMUX_DESER_PARITY_EN
    output logic              Parity_err,
`endif
    output logic [0:3]        Overflow
);
`ifdef DMUX_DESER_PARITY_EN
    localparam int WW = WORD_W + 1;
`else
    localparam int WW = WORD_W;
`endif
    logic [WW-1:0]  hold [NCH];
    logic [NCH-1:0] hold_v;
    logic [NCH-1:0] drain;
    state_t         state;
    ch_t            rr_ptr;
    ch_t            pick;
    logic           take;
    // first lane holding a word at or after rr_ptr; lowest offset wins
    always_comb begin
        pick = rr_ptr;
        for (int i = NCH - 1; i >= 0; i--)
            if (hold_v[rr_ptr + ch_t'(i)]) pick = rr_ptr + ch_t'(i);
    end
    assign take = |hold_v && (state == IDLE || Ready);
    for (genvar c = 0; c < NCH; c++) begin : g_lane
        assign drain[c] = take && pick == ch_t'(c);
        dmux_deser_lane #(.WW(WW)) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .clear  (Clear),
            .en     (Enable && S == ch_t'(c)),
            .din    (O[S]),
            .drain  (drain[c]),
            .hold   (hold[c]),
            .hold_v (hold_v[c]),
            .ovf    (Overflow[c])
        );
    end
    // output FSM: load a held word when idle or when the current one is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            Valid    <= 1'b0;
            Word_out <= '0;
            Ch_out   <= '0;
            rr_ptr   <= '0;
`ifdef DMUX_DESER_PARITY_EN
            Parity_err <= 1'b0;
`endif
        end else if (Clear) begin
            state    <= IDLE;
            Valid    <= 1'b0;
            Word_out <= '0;
            Ch_out   <= '0;
            rr_ptr   <= '0;
`ifdef DMUX_DESER_PARITY_EN
            Parity_err <= 1'b0;
`endif
        end else if (take) begin
            state    <= PRESENT;
            Valid    <= 1'b1;
            Word_out <= hold[pick][WW-1 -: WORD_W];
            Ch_out   <= pick;
            rr_ptr   <= pick + 1'b1;
`ifdef DMUX_DESER_PARITY_EN
            Parity_err <= ^hold[pick];
`endif
        end else if (state == PRESENT && Ready) begin
            state <= IDLE;
            Valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_dmux_deser.sv
// tb_dmux_deser: directed plus random stimulus checked against a word-level behavioural model
module tb_dmux_deser;
    localparam int W = 8;
`ifdef DMUX_DESER_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int WB = W + P;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         Enable = 1'b0;
    logic [1:0]   S = '0;
    logic [0:3]   O = '0;
    logic         Clear = 1'b0;
    logic         Ready = 1'b0;
    logic         Valid;
    logic [W-1:0] Word_out;
    logic [1:0]   Ch_out;
    logic [0:3]   Overflow;
`ifdef DMUX_DESER_PARITY_EN
    logic         Parity_err;
`endif

    always #5 clk = ~clk;

    dmux_deser #(.WORD_W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Enable     (Enable),
        .S          (S),
        .O          (O),
        .Clear      (Clear),
        .Ready      (Ready),
        .Valid      (Valid),
        .Word_out   (Word_out),
        .Ch_out     (Ch_out),
`ifdef DMUX_DESER_PARITY_EN
        .Parity_err (Parity_err),
`endif
        .Overflow   (Overflow)
    );

    int n_cmp = 0;
    int n_err = 0;
    int acc [4];
    int cnt [4];
    int mh [4];
    bit hv [4];
    bit mo [4];
    int rr;
    bit mv;
    int mw;
    int mc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 4; c++) begin
            acc[c] = 0; cnt[c] = 0; mh[c] = 0; hv[c] = 0; mo[c] = 0;
        end
        rr = 0; mv = 0; mw = 0; mc = 0;
    endtask

    task automatic model_edge(input bit en, input int s, input bit b, input bit clr, input bit rdy);
        int t;
        t = -1;
        if (clr) begin
            model_reset();
            return;
        end
        if (!mv || rdy)
            for (int k = 0; k < 4; k++)
                if (t < 0 && hv[(rr + k) % 4]) t = (rr + k) % 4;
        if (t >= 0) begin
            mw = mh[t]; mc = t; mv = 1; rr = (t + 1) % 4; hv[t] = 0;
        end else if (rdy) mv = 0;
        if (en) begin
            acc[s] = (acc[s] * 2 + int'(b)) % (1 << WB);
            cnt[s]++;
            if (cnt[s] == WB) begin
                cnt[s] = 0;
                if (hv[s]) mo[s] = 1;
                else begin
                    mh[s] = acc[s]; hv[s] = 1;
                end
            end
        end
    endtask

    task automatic check_model();
        logic [0:3] e;
        for (int c = 0; c < 4; c++) e[c] = mo[c];
        chk("valid", Valid, mv);
        if (mv) begin
            chk("word", Word_out, mw >> P);
            chk("ch", Ch_out, mc);
`ifdef DMUX_DESER_PARITY_EN
            chk("perr", Parity_err, $countones(mw) % 2);
`endif
        end
        chk("overflow", Overflow, e);
    endtask

    task automatic step(input bit en, input logic [1:0] s, input bit b, input bit clr, input bit rdy);
        Enable = en; S = s; O = 4'($urandom); O[s] = b; Clear = clr; Ready = rdy;
        @(posedge clk);
        model_edge(en, int'(s), b, clr, rdy);
        #1;
        check_model();
    endtask

    task automatic send(input logic [1:0] s, input logic [W-1:0] v, input bit rdy, input bit pbit);
        for (int i = W - 1; i >= 0; i--) step(1'b1, s, v[i], 1'b0, rdy);
`ifdef DMUX_DESER_PARITY_EN
        step(1'b1, s, pbit, 1'b0, rdy);
`endif
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", Valid, 0);
        chk("rst_word", Word_out, 0);
        chk("rst_ch", Ch_out, 0);
        chk("rst_ovf", Overflow, 0);
        rst_n = 1'b1;

        send(2'd2, 8'hA5, 1'b1, ^8'hA5);
        chk("t1_early", Valid, 0);
        step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        chk("t1_valid", Valid, 1);
        chk("t1_word", Word_out, 8'hA5);
        chk("t1_ch", Ch_out, 2);
        step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        chk("t1_one_cycle", Valid, 0);

        for (int i = W - 1; i >= 0; i--) begin
            step(1'b1, 2'd0, (i < 4), 1'b0, 1'b1);
            step(1'b1, 2'd3, (i >= 4), 1'b0, 1'b1);
        end
`ifdef DMUX_DESER_PARITY_EN
        step(1'b1, 2'd0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 2'd3, 1'b0, 1'b0, 1'b1);
`endif
        chk("t2_first_ch", Ch_out, 0);
        chk("t2_first_word", Word_out, 8'h0F);
        step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        chk("t2_second_ch", Ch_out, 3);
        chk("t2_second_word", Word_out, 8'hF0);
        step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);

        send(2'd1, 8'h11, 1'b0, ^8'h11);
        send(2'd1, 8'h22, 1'b0, ^8'h22);
        send(2'd1, 8'h33, 1'b0, ^8'h33);
        chk("t3_hold_word", Word_out, 8'h11);
        chk("t3_ovf", Overflow, 4'b0100);
        step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        chk("t3_second", Word_out, 8'h22);
        step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        chk("t3_drained", Valid, 0);

        for (int i = 0; i < 4; i++) step(1'b1, 2'd0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 2'd0, 1'b0, 1'b1, 1'b1);
        chk("t4_clr_valid", Valid, 0);
        chk("t4_clr_ovf", Overflow, 0);
        send(2'd0, 8'hC3, 1'b1, ^8'hC3);
        step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        chk("t4_word", Word_out, 8'hC3);

        send(2'd2, 8'h5A, 1'b0, ^8'h5A);
        step(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        chk("t5_pre_valid", Valid, 1);
        for (int i = 0; i < 3; i++) step(1'b1, 2'd2, 1'b1, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_valid", Valid, 0);
        chk("t5_async_word", Word_out, 0);
        chk("t5_async_ch", Ch_out, 0);
        model_reset();
        #1 rst_n = 1'b1;
        send(2'd2, 8'h96, 1'b1, ^8'h96);
        step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        chk("t5_word", Word_out, 8'h96);

`ifdef DMUX_DESER_PARITY_EN
        send(2'd2, 8'hA5, 1'b1, 1'b0);
        step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        chk("t6_perr0", Parity_err, 0);
        send(2'd2, 8'hA5, 1'b1, 1'b1);
        step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        chk("t6_perr1", Parity_err, 1);
        chk("t6_word", Word_out, 8'hA5);
`endif

        for (int n = 0; n < 3000; n++)
            step($urandom_range(0, 3) != 0, 2'($urandom), 1'($urandom),
                 $urandom_range(0, 99) == 0, $urandom_range(0, 2) != 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
